// File: rtl/i2s_tx.sv
// I2S (Philips) transmitter: a one-entry stereo sample buffer feeds 64-slot frames
// serialised on a divided bit clock, with WS leading each channel MSB by one bit.
//
// state | meaning
// IDLE  | bit clock, WS and SD held low; buffer still accepts one sample
// RUN   | frames stream continuously; leaving only at a frame boundary
module i2s_tx #(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int I2S_CLK_FREQ = 1_500_000,
    parameter int DATA_SIZE    = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 sample_valid,
    output logic                 sample_ready,
    input  logic [DATA_SIZE-1:0] sample_left,
    input  logic [DATA_SIZE-1:0] sample_right,
    output logic                 i2s_clk,
    output logic                 i2s_ws,
    output logic                 i2s_sd,
    output logic                 underrun,
    output logic                 busy
);

    localparam int DIV_RAW = CLK_FREQ / (2 * I2S_CLK_FREQ);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t                 state_q, state_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic                   bck_q, bck_d;
    logic                   ws_q, ws_d;
    logic [5:0]             bit_cnt_q, bit_cnt_d;
    logic [63:0]            frame_q, frame_d;
    logic                   buf_full_q, buf_full_d;
    logic [DATA_SIZE-1:0]   buf_l_q, buf_l_d;
    logic [DATA_SIZE-1:0]   buf_r_q, buf_r_d;
    logic                   underrun_q, underrun_d;

    logic                   accept;
    logic                   tick;
    logic                   fall;
    logic                   frame_end;
    logic                   load;
    logic [5:0]             slot_nxt;

    // Each channel is MSB-aligned in its 32-slot half; unused low slots stay zero.
    function automatic logic [63:0] pack_frame(input logic [DATA_SIZE-1:0] l,
                                               input logic [DATA_SIZE-1:0] r);
        logic [31:0] l32;
        logic [31:0] r32;
        l32 = 32'(l) << (32 - DATA_SIZE);
        r32 = 32'(r) << (32 - DATA_SIZE);
        return {l32, r32};
    endfunction

    assign accept    = sample_valid && !buf_full_q;
    assign tick      = (div_q == '0);
    assign fall      = (state_q == S_RUN) && tick && bck_q;
    assign frame_end = fall && (bit_cnt_q == 6'd63);
    assign slot_nxt  = bit_cnt_q + 6'd1;

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bck_d      = bck_q;
        ws_d       = ws_q;
        bit_cnt_d  = bit_cnt_q;
        frame_d    = frame_q;
        buf_full_d = buf_full_q;
        buf_l_d    = buf_l_q;
        buf_r_d    = buf_r_q;
        underrun_d = 1'b0;
        load       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable) load = 1'b1;
            end
            S_RUN: begin
                if (tick) begin
                    div_d = DIV_LAST;
                    bck_d = ~bck_q;
                end else begin
                    div_d = div_q - DIV_W'(1);
                end
                if (frame_end) begin
                    if (enable) begin
                        load = 1'b1;
                    end else begin
                        state_d   = S_IDLE;
                        div_d     = '0;
                        bck_d     = 1'b0;
                        ws_d      = 1'b0;
                        bit_cnt_d = '0;
                        frame_d   = '0;
                    end
                end else if (fall) begin
                    bit_cnt_d = slot_nxt;
                    frame_d   = {frame_q[62:0], 1'b0};
                    ws_d      = (slot_nxt >= 6'd31) && (slot_nxt <= 6'd62);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            buf_full_d = 1'b1;
            buf_l_d    = sample_left;
            buf_r_d    = sample_right;
        end

        // A sample arriving on the load edge into an empty buffer bypasses it.
        if (load) begin
            state_d   = S_RUN;
            div_d     = DIV_LAST;
            bck_d     = 1'b0;
            ws_d      = 1'b0;
            bit_cnt_d = '0;
            if (buf_full_q) begin
                frame_d    = pack_frame(buf_l_q, buf_r_q);
                buf_full_d = 1'b0;
            end else if (accept) begin
                frame_d    = pack_frame(sample_left, sample_right);
                buf_full_d = 1'b0;
            end else begin
                frame_d    = '0;
                underrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            bck_q      <= 1'b0;
            ws_q       <= 1'b0;
            bit_cnt_q  <= '0;
            frame_q    <= '0;
            buf_full_q <= 1'b0;
            buf_l_q    <= '0;
            buf_r_q    <= '0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bck_q      <= bck_d;
            ws_q       <= ws_d;
            bit_cnt_q  <= bit_cnt_d;
            frame_q    <= frame_d;
            buf_full_q <= buf_full_d;
            buf_l_q    <= buf_l_d;
            buf_r_q    <= buf_r_d;
            underrun_q <= underrun_d;
        end
    end

    assign sample_ready = !buf_full_q;
    assign i2s_clk      = bck_q;
    assign i2s_ws       = ws_q;
    assign i2s_sd       = frame_q[63];
    assign underrun     = underrun_q;
    assign busy         = (state_q == S_RUN);

endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 SHALL provide parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL provide parameter I2S_CLK_FREQ, default 1_500_000, target bit-clock frequency in Hz.
REQ-003 SHALL provide parameter DATA_SIZE, default 24, bits per channel sample (1..32).
REQ-004 SHALL provide port clk, input, 1, the single system clock.
REQ-005 SHALL provide port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL provide port enable, input, 1, request to run the serial stream.
REQ-007 SHALL provide port sample_valid, input, 1, stereo sample offered.
REQ-008 SHALL provide port sample_ready, output, 1, buffer can accept a sample.
REQ-009 SHALL provide port sample_left, input, DATA_SIZE, left sample, two's complement.
REQ-010 SHALL provide port sample_right, input, DATA_SIZE, right sample, two's complement.
REQ-011 SHALL provide port i2s_clk, output, 1, serial bit clock.
REQ-012 SHALL provide port i2s_ws, output, 1, word select (0 = left, 1 = right).
REQ-013 SHALL provide port i2s_sd, output, 1, serial data to DAC/amplifier.
REQ-014 SHALL provide port underrun, output, 1, one-clk pulse when a frame starts with no buffered sample.
REQ-015 SHALL provide port busy, output, 1, high while in RUN.

Function
REQ-016 SHALL compute DIV = max(1, CLK_FREQ / (2*I2S_CLK_FREQ)), integer division; i2s_clk toggles every DIV clk cycles in RUN (default DIV=16, period 32 clk).
REQ-017 SHALL implement FSM IDLE/RUN; IDLE->RUN on first clk with enable=1; RUN->IDLE only at frame end (REQ-022) with enable=0.
REQ-018 SHALL contain a one-entry input buffer; sample_ready = buffer empty; transfer on clk edge where sample_valid && sample_ready; data SHALL be held until consumed.
REQ-019 SHALL, on entering RUN and at every frame end with enable=1, load the 64-bit shift frame from the buffer (left MSB-aligned in slots 0..31, right in 32..63, slots DATA_SIZE..31 of each half zero) and empty the buffer; if buffer empty, load all zeros and pulse underrun for one clk.
REQ-020 SHALL keep a 6-bit slot counter bit_cnt, 0 on frame load, incremented at each i2s_clk falling edge, wrapping 63->0.
REQ-021 SHALL drive i2s_sd and i2s_ws only at i2s_clk falling edges (and at frame load): i2s_sd = frame bit of current slot (left MSB at slot 0, right MSB at slot 32); i2s_ws = 1 for slots 31..62, 0 otherwise (WS leads MSB by one bit clock, Philips format).
REQ-022 SHALL treat the falling edge where bit_cnt wraps 63->0 as frame end; reload (REQ-019) occurs on that same clk edge so no extra bit clock is inserted.
REQ-023 SHALL, when a buffer load by REQ-019 coincides with sample_valid && sample_ready, take the frame from the pre-existing buffer content and let the incoming sample refill the buffer in the same cycle only if the buffer was full before; if empty, the incoming sample SHALL go directly into the frame and no underrun SHALL pulse.
REQ-024 SHALL, in IDLE, hold i2s_clk=0, i2s_ws=0, i2s_sd=0, divider and bit_cnt at 0; buffer contents SHALL persist and sample_ready SHALL still follow REQ-018.
REQ-025 SHALL ignore enable deassertion mid-frame; the current frame completes fully.

Reset
REQ-026 SHALL, on rst_n=0 asynchronously, force IDLE, buffer empty, sample_ready=1, i2s_clk=0, i2s_ws=0, i2s_sd=0, underrun=0, busy=0, counters 0; reset mid-frame SHALL abort the frame immediately.
REQ-027 SHALL resume normal operation on the first clk edge after rst_n deasserts.

Verification
REQ-028 Buffer left=0xA5A5A5, right=0x5A5A5A, enable=1 -> i2s_clk period 32 clk; sd reproduces 0xA5A5A5 MSB-first in slots 0..23, zeros 24..31, 0x5A5A5A in 32..55; ws high slots 31..62.
REQ-029 enable=1 with empty buffer -> underrun one-clk pulse at start, frame all zeros, pulse repeats every 2048 clk until a sample is written.
REQ-030 Continuous valid stream of counting samples -> sample_ready drops after each accept, reasserts at each frame load; every sample appears exactly once, no underrun.
REQ-031 enable dropped at slot 10 -> frame completes through slot 63, then busy=0, i2s_clk/ws/sd held 0.
REQ-032 rst_n pulsed low at slot 40 -> all outputs at reset values within the same cycle, sample_ready=1, queued sample discarded.
REQ-033 sample_valid asserted on the exact frame-load clk with buffer empty -> that sample transmitted in the new frame, underrun stays 0.
